// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back / write-allocate data cache.
// One 128-bit line (four 32-bit words) per entry, NUM_LINES entries.
// A miss optionally evicts a dirty victim (WRITEBACK), idles for one cycle
// (GAP), refills the line (REFILL), then replays the latched request as a hit.
// Optional feature macro: DCACHE_STATS_EN adds saturating Hit_count/Miss_count.
module data_cache #(
    parameter int  NUM_LINES       = 4,
    localparam int WORD_SIZE       = 32,
    localparam int CACHE_LINE_SIZE = 128,
    localparam int INDEX_SIZE      = $clog2(NUM_LINES),
    localparam int MA_W            = WORD_SIZE - INDEX_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Req_valid,
    input  logic                       Req_write,
    input  logic [WORD_SIZE-1:0]       Req_addr,
    input  logic [WORD_SIZE-1:0]       Req_wdata,
    output logic                       Req_ready,
    output logic [WORD_SIZE-1:0]       Rsp_rdata,
    output logic                       Stall,
    output logic [MA_W-1:0]            Mem_Address,
    output logic [CACHE_LINE_SIZE-1:0] Mem_Line_out,
    input  logic [CACHE_LINE_SIZE-1:0] Mem_Line_in,
    output logic                       Mem_Read,
    output logic                       Mem_Write,
    input  logic                       Mem_Ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]                Hit_count,
    output logic [15:0]                Miss_count
`endif
);

    localparam int TAG_W   = WORD_SIZE - 4 - INDEX_SIZE;
    localparam int LADDR_W = WORD_SIZE - 4;

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        WRITEBACK = 2'd1,
        GAP       = 2'd2,
        REFILL    = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Per-line bookkeeping; valid/dirty are reset, tag/data are not.
    logic [NUM_LINES-1:0]       valid_q, dirty_q;
    logic [TAG_W-1:0]           tag_q  [NUM_LINES];
    logic [CACHE_LINE_SIZE-1:0] data_q [NUM_LINES];

    // Latched copy of the missing request; byte-offset bits are never needed.
    logic [WORD_SIZE-1:2] req_addr_q;
    logic                 req_write_q;
    logic [WORD_SIZE-1:0] req_wdata_q;
    logic                 replay_q;

    logic                  unused_addr_bits;
    logic                  lookup, new_req, hit, req_hit, req_miss;
    logic                  victim_dirty, wb_done, refill_done, store_commit;
    logic [WORD_SIZE-1:2]  act_addr;
    logic [INDEX_SIZE-1:0] act_idx;
    logic [TAG_W-1:0]      act_tag;
    logic [1:0]            act_word;
    logic                  act_write;
    logic [WORD_SIZE-1:0]  act_wdata;
    logic [WORD_SIZE-1:0]  line_word;

    assign unused_addr_bits = ^Req_addr[1:0];

    // While idle in LOOKUP the live request addresses the array; during a
    // miss and its replay only the latched copy is used.
    assign lookup    = (state_q == LOOKUP);
    assign act_addr  = (lookup && !replay_q) ? Req_addr[WORD_SIZE-1:2] : req_addr_q;
    assign act_write = replay_q ? req_write_q : Req_write;
    assign act_wdata = replay_q ? req_wdata_q : Req_wdata;
    assign act_idx   = act_addr[4 +: INDEX_SIZE];
    assign act_tag   = act_addr[WORD_SIZE-1 -: TAG_W];
    assign act_word  = act_addr[3:2];

    assign hit          = valid_q[act_idx] && (tag_q[act_idx] == act_tag);
    assign new_req      = rst && lookup && !replay_q && Req_valid;
    assign req_hit      = new_req && hit;
    assign req_miss     = new_req && !hit;
    assign victim_dirty = valid_q[act_idx] && dirty_q[act_idx];
    assign wb_done      = (state_q == WRITEBACK) && Mem_Ready;
    assign refill_done  = (state_q == REFILL) && Mem_Ready;
    assign store_commit = Req_ready && act_write;
    assign line_word    = data_q[act_idx][{act_word, 5'd0} +: WORD_SIZE];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LOOKUP;
        else      state_q <= state_d;
    end

    // Next-state logic; miss latency is set entirely by Mem_Ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOOKUP:    if (req_miss) state_d = victim_dirty ? WRITEBACK : REFILL;
            WRITEBACK: if (Mem_Ready) state_d = GAP;
            GAP:       state_d = REFILL;
            REFILL:    if (Mem_Ready) state_d = LOOKUP;
            default:   state_d = LOOKUP;
        endcase
    end

    // Outputs; everything memory-facing is zero outside its own state.
    always_comb begin
        Req_ready    = lookup && (replay_q || req_hit);
        Stall        = !lookup || req_miss;
        Rsp_rdata    = Req_ready ? line_word : '0;
        Mem_Write    = (state_q == WRITEBACK);
        Mem_Read     = (state_q == REFILL);
        Mem_Address  = '0;
        Mem_Line_out = '0;
        if (state_q == WRITEBACK) begin
            Mem_Address  = MA_W'({tag_q[act_idx], act_idx});
            Mem_Line_out = data_q[act_idx];
        end else if (state_q == REFILL) begin
            Mem_Address  = MA_W'(req_addr_q[WORD_SIZE-1:4]);
        end
    end

    // Control state: latch misses, track valid/dirty, arm the replay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            replay_q    <= 1'b0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
        end else begin
            replay_q <= refill_done;
            if (req_miss) begin
                req_addr_q  <= Req_addr[WORD_SIZE-1:2];
                req_write_q <= Req_write;
                req_wdata_q <= Req_wdata;
            end
            if (wb_done) dirty_q[act_idx] <= 1'b0;
            if (refill_done) begin
                valid_q[act_idx] <= 1'b1;
                dirty_q[act_idx] <= 1'b0;
            end
            if (store_commit) dirty_q[act_idx] <= 1'b1;
        end
    end

    // Tag/data array: refill overwrites the line, stores merge one word.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_q[act_idx]  <= act_tag;
            data_q[act_idx] <= Mem_Line_in;
        end
        if (store_commit) data_q[act_idx][{act_word, 5'd0} +: WORD_SIZE] <= act_wdata;
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating counters; replays are not counted as hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (req_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (req_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign Hit_count  = hit_cnt_q;
    assign Miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL take parameter NUM_LINES, default 4 (power of 2, >=2): number of direct-mapped cache lines.
REQ-002 The module SHALL size all widths from the shared constants: WORD_SIZE (32), CACHE_LINE_SIZE (128, four words), INDEX_SIZE.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The module SHALL have ports as follows (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- Req_valid  in  1  CPU access request.
- Req_write  in  1  1=store, 0=load.
- Req_addr  in  WORD_SIZE  byte address; bits [1:0] ignored.
- Req_wdata  in  WORD_SIZE  store data.
- Req_ready  out  1  one-cycle completion pulse.
- Rsp_rdata  out  WORD_SIZE  load data, valid while Req_ready=1.
- Stall  out  1  miss in progress.
- Mem_Address  out  WORD_SIZE-INDEX_SIZE  line address to data memory.
- Mem_Line_out  out  CACHE_LINE_SIZE  writeback line to memory Line_in.
- Mem_Line_in  in  CACHE_LINE_SIZE  refill line from memory Line_out.
- Mem_Read, Mem_Write  out  1  memory commands, never both high.
- Mem_Ready  in  1  memory completion.

Function
REQ-005 The module SHALL split Req_addr into: word offset [3:2]; index [3+log2(NUM_LINES):4]; tag = remaining upper bits. Line address = Req_addr>>4, truncated to Mem_Address width.
REQ-006 The module SHALL keep valid, dirty and tag per line; policy is write-back, write-allocate.
REQ-007 The module SHALL use FSM states LOOKUP, WRITEBACK, GAP, REFILL, with reset state LOOKUP.
REQ-008 In LOOKUP with Req_valid=1 and hit (valid and tag equal), the module SHALL behave as follows:
- Req_ready=1 in the same cycle.
- Load: Rsp_rdata = the addressed word, combinational.
- Store: the word is written and dirty set at the next edge.
- Stall stays 0.
REQ-009 In LOOKUP with Req_valid=1 and miss, the module SHALL latch Req_addr, Req_write and Req_wdata, assert Stall, and go to WRITEBACK if the victim is valid and dirty, else to REFILL.
REQ-010 In WRITEBACK the module SHALL hold Mem_Write=1, Mem_Address={victim tag, index} and Mem_Line_out=victim line; on the first edge where Mem_Ready=1 it SHALL clear dirty and go to GAP.
REQ-011 The GAP state SHALL last exactly one cycle with Mem_Read=Mem_Write=0, so the memory's latency pipeline drains before the next command, then go to REFILL.
REQ-012 In REFILL the module SHALL hold Mem_Read=1 with the latched line address; on the first edge where Mem_Ready=1 it SHALL write Mem_Line_in, the tag and valid=1, dirty=0 into the line and return to LOOKUP.
REQ-013 On return to LOOKUP the latched request SHALL be replayed as a hit: Req_ready pulses, and a store merges its word and sets dirty. Stall drops in that same cycle.
REQ-014 The requester SHALL hold Req_* stable while Stall=1; the module SHALL use only the latched copy during a miss.
REQ-015 Mem_Read and Mem_Write SHALL be 0 in LOOKUP; miss-handling latency is unbounded and is set by Mem_Ready.
REQ-016 Req_valid=0 in LOOKUP SHALL produce no state change; Req_ready=0 and Stall=0.

Reset
REQ-017 While rst=0 the module SHALL immediately force:
- all valid and dirty bits to 0;
- state to LOOKUP;
- Req_ready, Stall, Mem_Read and Mem_Write to 0;
- Rsp_rdata, Mem_Address and Mem_Line_out to 0.
REQ-018 On reset during WRITEBACK or REFILL the module SHALL abandon the transfer with no write to any line; dirty data is lost.

Configuration
REQ-019 With DCACHE_STATS_EN defined, the module SHALL add outputs Hit_count and Miss_count (16 bits each, reset to 0, saturating at 0xFFFF), counted as follows:
- Hit_count increments per REQ-008 hit, excluding replays.
- Miss_count increments per REQ-009 miss.
Without the macro these ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-020 Load miss on clean line: load 0x0000_0014 after reset -> Stall=1; Mem_Read=1, Mem_Address=0x1 until Mem_Ready; then Req_ready pulses with Rsp_rdata = word1 of the line; no Mem_Write seen.
REQ-021 Hits: store 0xDEADBEEF to 0x14, then load 0x14 -> both Req_ready in the same cycle as Req_valid; Rsp_rdata=0xDEADBEEF; no memory traffic.
REQ-022 Dirty eviction: with line 1 dirty, load 0x54 (NUM_LINES=4) -> the following sequence:
- Mem_Write at Mem_Address=0x1 carrying 0xDEADBEEF in word1;
- exactly one idle cycle;
- Mem_Read at 0x5;
- then Req_ready.
REQ-023 Store miss: store 0x12345678 to 0x28 on invalid line 2 -> refill, then the line holds the refilled words with word2=0x12345678 and dirty=1.
REQ-024 Reset mid-REFILL: drop rst while Mem_Read=1 -> Mem_Read=0 immediately; a subsequent load of the same address misses again.
REQ-025 With DCACHE_STATS_EN: the REQ-020..REQ-022 sequence -> Miss_count=2, Hit_count=2.
